// File: rtl/sprite_move_2d.sv
// sprite_move_2d
//   Moves a sprite in 2D with per-frame acceleration, speed saturation,
//   collision blocking against latched hit edges and clamping to a box.
//   Position and speed are signed 32-bit fixed point with FRAC_BITS
//   fraction bits. All motion state updates on startOfFrame.
//
// Ports
//   clk          : single clock
//   reset        : synchronous, active-high
//   startOfFrame : one-cycle pulse per frame; the update edge
//   moveLeft/Right/Up/Down : level requests (opposite pair cancels)
//   collision    : object overlaps an obstacle this cycle
//   HitEdgeCode  : edges hit, {Left,Top,Right,Bottom}
//   topLeftX/Y   : pixel position (signed 11-bit)
//   moving       : either axis speed is non-zero
//   atBound      : pixel position sits on {X_MIN,Y_MIN,X_MAX,Y_MAX}
module sprite_move_2d #(
  parameter int INITIAL_X = 280,
  parameter int INITIAL_Y = 185,
  parameter int FRAC_BITS = 6,
  parameter int ACCEL     = 16,
  parameter int MAX_SPEED = 640,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 607,
  parameter int Y_MIN     = 0,
  parameter int Y_MAX     = 447
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               moveLeft,
  input  logic               moveRight,
  input  logic               moveUp,
  input  logic               moveDown,
  input  logic               collision,
  input  logic [3:0]         HitEdgeCode,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic               moving,
  output logic [3:0]         atBound
);

  localparam int SCALE  = 2 ** FRAC_BITS;
  localparam int X_INIT = INITIAL_X * SCALE;
  localparam int Y_INIT = INITIAL_Y * SCALE;
  localparam int X_LO   = X_MIN * SCALE;
  localparam int X_HI   = X_MAX * SCALE;
  localparam int Y_LO   = Y_MIN * SCALE;
  localparam int Y_HI   = Y_MAX * SCALE;

  localparam logic signed [10:0] X_MIN_PX = 11'(X_MIN);
  localparam logic signed [10:0] X_MAX_PX = 11'(X_MAX);
  localparam logic signed [10:0] Y_MIN_PX = 11'(Y_MIN);
  localparam logic signed [10:0] Y_MAX_PX = 11'(Y_MAX);

  logic signed [31:0] pos_x, pos_y;
  logic signed [31:0] spd_x, spd_y;
  logic signed [31:0] prev_x, prev_y;
  logic [3:0]         hit_latch;

  logic [3:0]         hits;
  logic signed [31:0] pos_x_nxt, pos_y_nxt;
  logic signed [31:0] spd_x_nxt, spd_y_nxt;

  // Clamp a speed to +/-MAX_SPEED.
  function automatic logic signed [31:0] sat_speed(input logic signed [31:0] s);
    if (s > MAX_SPEED)  return MAX_SPEED;
    if (s < -MAX_SPEED) return -MAX_SPEED;
    return s;
  endfunction

  // inc/dec are the positive/negative direction requests of one axis.
  // Pressing against the current motion reverses at once rather than
  // decelerating through zero.
  function automatic logic signed [31:0] next_speed(input logic signed [31:0] spd,
                                                    input logic inc, input logic dec);
    logic signed [31:0] step;
    if (inc == dec) return '0;
    step = inc ? ACCEL : -ACCEL;
    if ((inc && spd < 0) || (dec && spd > 0)) return step;
    return sat_speed(spd + step);
  endfunction

  // One axis update: a hit edge only blocks when the new speed points into
  // it; a blocked axis snaps back to the previous-frame position.
  function automatic void axis_step(
    input  logic signed [31:0] pos, spd, prev,
    input  logic               inc, dec, hit_neg, hit_pos,
    input  logic signed [31:0] lo, hi,
    output logic signed [31:0] pos_o, spd_o
  );
    logic signed [31:0] s, cand;
    s    = next_speed(spd, inc, dec);
    cand = pos + s;
    if ((hit_neg && s < 0) || (hit_pos && s > 0)) begin
      pos_o = prev;
      spd_o = '0;
    end else if (cand < lo) begin
      pos_o = lo;
      spd_o = '0;
    end else if (cand > hi) begin
      pos_o = hi;
      spd_o = '0;
    end else begin
      pos_o = cand;
      spd_o = s;
    end
  endfunction

  // A collision arriving on the frame edge itself still counts this frame.
  assign hits = hit_latch | (collision ? HitEdgeCode : 4'b0000);

  always_comb begin
    axis_step(pos_x, spd_x, prev_x, moveRight, moveLeft, hits[3], hits[1],
              X_LO, X_HI, pos_x_nxt, spd_x_nxt);
    axis_step(pos_y, spd_y, prev_y, moveDown, moveUp, hits[2], hits[0],
              Y_LO, Y_HI, pos_y_nxt, spd_y_nxt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_x     <= X_INIT;
      pos_y     <= Y_INIT;
      prev_x    <= X_INIT;
      prev_y    <= Y_INIT;
      spd_x     <= '0;
      spd_y     <= '0;
      hit_latch <= '0;
    end else if (startOfFrame) begin
      prev_x    <= pos_x;
      prev_y    <= pos_y;
      pos_x     <= pos_x_nxt;
      pos_y     <= pos_y_nxt;
      spd_x     <= spd_x_nxt;
      spd_y     <= spd_y_nxt;
      hit_latch <= '0;
    end else if (collision) begin
      hit_latch <= hit_latch | HitEdgeCode;
    end
  end

  // Slicing equals arithmetic shift right then truncate to 11 bits.
  assign topLeftX = pos_x[FRAC_BITS +: 11];
  assign topLeftY = pos_y[FRAC_BITS +: 11];
  assign moving   = (spd_x != '0) || (spd_y != '0);
  assign atBound  = {topLeftX == X_MIN_PX, topLeftY == Y_MIN_PX,
                     topLeftX == X_MAX_PX, topLeftY == Y_MAX_PX};

endmodule

// File: tb/tb_sprite_move_2d.sv
// Testbench for sprite_move_2d: directed scenarios plus randomized frames,
// compared against a frame-level integer reference model.
module tb_sprite_move_2d;

  localparam int F      = 6;
  localparam int ACC    = 16;
  localparam int MAXS   = 640;
  localparam int XMIN   = 0;
  localparam int XMAX   = 607;
  localparam int YMIN   = 0;
  localparam int YMAX   = 447;
  localparam int INIT_X = 280;
  localparam int INIT_Y = 185;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic startOfFrame = 1'b0;
  logic moveLeft = 1'b0, moveRight = 1'b0, moveUp = 1'b0, moveDown = 1'b0;
  logic collision = 1'b0;
  logic [3:0] HitEdgeCode = 4'b0000;
  logic signed [10:0] topLeftX, topLeftY;
  logic moving;
  logic [3:0] atBound;

  int tests = 0;
  int fails = 0;

  // reference model state (positions and speeds in fixed-point units)
  int mpx, mpy, msx, msy, mprx, mpry;
  logic [3:0] mlatch;

  sprite_move_2d dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
    .moveLeft(moveLeft), .moveRight(moveRight), .moveUp(moveUp), .moveDown(moveDown),
    .collision(collision), .HitEdgeCode(HitEdgeCode),
    .topLeftX(topLeftX), .topLeftY(topLeftY), .moving(moving), .atBound(atBound)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    mpx = INIT_X * 64; mpy = INIT_Y * 64;
    mprx = mpx; mpry = mpy;
    msx = 0; msy = 0; mlatch = 4'b0000;
  endfunction

  // Speed rule and position rule for one axis, from the frame semantics.
  function automatic void mdl_axis(input int pos, input int spd, input int prev,
                                   input int dir, input bit hneg, input bit hpos,
                                   input int lo, input int hi,
                                   output int npos, output int nspd);
    int s;
    int c;
    if (dir == 0) s = 0;
    else if (dir * spd < 0) s = dir * ACC;
    else begin
      s = spd + dir * ACC;
      if (s > MAXS) s = MAXS;
      if (s < -MAXS) s = -MAXS;
    end
    c = pos + s;
    if ((hneg && s < 0) || (hpos && s > 0)) begin npos = prev; nspd = 0; end
    else if (c < lo) begin npos = lo; nspd = 0; end
    else if (c > hi) begin npos = hi; nspd = 0; end
    else begin npos = c; nspd = s; end
  endfunction

  function automatic void model_frame();
    logic [3:0] h;
    int nx, ny, nsx, nsy;
    h = mlatch | (collision ? HitEdgeCode : 4'b0000);
    mdl_axis(mpx, msx, mprx, int'(moveRight) - int'(moveLeft), h[3], h[1],
             XMIN * 64, XMAX * 64, nx, nsx);
    mdl_axis(mpy, msy, mpry, int'(moveDown) - int'(moveUp), h[2], h[0],
             YMIN * 64, YMAX * 64, ny, nsy);
    mprx = mpx; mpry = mpy;
    mpx = nx; mpy = ny; msx = nsx; msy = nsy;
    mlatch = 4'b0000;
  endfunction

  // One clock with the current inputs; the model follows the same edge.
  task automatic step();
    @(posedge clk);
    if (reset) model_reset();
    else if (startOfFrame) model_frame();
    else if (collision) mlatch = mlatch | HitEdgeCode;
    #1;
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_all(input string tag);
    int tx, ty;
    logic [3:0] ab;
    tx = mpx >>> F;
    ty = mpy >>> F;
    ab = {tx == XMIN, ty == YMIN, tx == XMAX, ty == YMAX};
    chk({tag, "_x"}, topLeftX, tx);
    chk({tag, "_y"}, topLeftY, ty);
    chk({tag, "_spdx"}, dut.spd_x, msx);
    chk({tag, "_spdy"}, dut.spd_y, msy);
    chk({tag, "_moving"}, moving, (msx != 0 || msy != 0) ? 1 : 0);
    chk({tag, "_atb"}, atBound, ab);
  endtask

  task automatic pulse_hit(input logic [3:0] code);
    collision = 1'b1; HitEdgeCode = code;
    step();
    collision = 1'b0; HitEdgeCode = 4'b0000;
  endtask

  initial begin
    int t_before;
    int k;
    model_reset();

    // reset state
    idle(2);
    reset = 1'b0;
    chk("rst_x", topLeftX, 280);
    chk("rst_y", topLeftY, 185);
    chk("rst_moving", moving, 0);
    chk("rst_atb", atBound, 0);
    check_all("rst");
    idle(3);
    check_all("hold_noframe");

    // three frames of moveRight
    moveRight = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      idle(2);
      frame();
      chk("acc3_spd", dut.spd_x, 16 * i);
      check_all("acc3");
    end
    chk("acc3_posx", dut.pos_x, 18016);
    chk("acc3_tlx", topLeftX, 281);

    // continue to 45 frames: saturation
    for (int i = 4; i <= 44; i++) begin
      idle(1);
      frame();
      check_all("acc45");
    end
    chk("sat_spd", dut.spd_x, 640);
    t_before = mpx >>> F;
    idle(1);
    frame();
    check_all("acc45_last");
    chk("sat_step", topLeftX, t_before + 10);

    // right-edge hit while moving right blocks and restores prior frame
    idle(1);
    pulse_hit(4'b0010);
    idle(1);
    frame();
    chk("hitR_back", topLeftX, t_before);
    chk("hitR_spd", dut.spd_x, 0);
    check_all("hitR");

    // left-edge hit does not oppose rightward motion
    idle(1);
    frame();
    pulse_hit(4'b1000);
    frame();
    chk("hitL_spd", dut.spd_x, 32);
    check_all("hitL");

    // collision on the frame edge itself is applied
    collision = 1'b1; HitEdgeCode = 4'b0010;
    frame();
    collision = 1'b0; HitEdgeCode = 4'b0000;
    chk("hitsof_spd", dut.spd_x, 0);
    check_all("hitsof");

    // up into Y_MIN with left+right cancelling
    moveUp = 1'b1; moveLeft = 1'b1; moveRight = 1'b1;
    t_before = mpx >>> F;
    k = 0;
    while (mpy != 0 && k < 40) begin
      frame();
      check_all("up");
      k++;
    end
    chk("up_y", topLeftY, 0);
    chk("up_spdy", dut.spd_y, 0);
    chk("up_atb2", atBound[2], 1);
    chk("up_spdx", dut.spd_x, 0);
    chk("up_x", topLeftX, t_before);
    moveUp = 1'b0; moveLeft = 1'b0;

    // mid-frame reset discards speed and latched hits
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < 3; i++) frame();
    pulse_hit(4'b1111);
    reset = 1'b1; step(); reset = 1'b0;
    chk("rr_x", topLeftX, 280);
    chk("rr_y", topLeftY, 185);
    chk("rr_moving", moving, 0);
    frame();
    chk("rr_spd", dut.spd_x, 16);
    chk("rr_pos", dut.pos_x, 17936);
    check_all("rr");

    // reset dominates startOfFrame
    reset = 1'b1; startOfFrame = 1'b1; step();
    reset = 1'b0; startOfFrame = 1'b0;
    chk("rdom_pos", dut.pos_x, 17920);
    check_all("rdom");

    // randomized frames
    for (int i = 0; i < 300; i++) begin
      moveLeft  = ($urandom_range(0, 2) == 0);
      moveRight = ($urandom_range(0, 1) == 0);
      moveUp    = ($urandom_range(0, 2) == 0);
      moveDown  = ($urandom_range(0, 1) == 0);
      if (i % 100 == 50) moveRight = 1'b1;
      for (int j = $urandom_range(0, 3); j > 0; j--) begin
        collision = ($urandom_range(0, 4) == 0);
        HitEdgeCode = 4'($urandom_range(0, 15));
        step();
      end
      collision = ($urandom_range(0, 5) == 0);
      HitEdgeCode = 4'($urandom_range(0, 15));
      reset = ($urandom_range(0, 49) == 0);
      frame();
      reset = 1'b0; collision = 1'b0; HitEdgeCode = 4'b0000;
      check_all("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
